// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, immediate formats and the decoded-entry layout shared by the decode stage.
package decode_pkg;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_ARI_I  = 7'b0010011;
    localparam logic [6:0] OPC_ARI_R  = 7'b0110011;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       rd_we;
        logic       illegal;
    } dec_fields_t;

    localparam int FIELDS_W = $bits(dec_fields_t);

    // Unknown opcodes fall through to R-type.
    function automatic imm_fmt_e fmt_of(input logic [6:0] opc);
        return (opc == OPC_LUI || opc == OPC_AUIPC) ? FMT_U :
               opc == OPC_JAL ? FMT_J :
               (opc == OPC_JALR || opc == OPC_LOAD || opc == OPC_ARI_I) ? FMT_I :
               opc == OPC_STORE ? FMT_S :
               opc == OPC_BRANCH ? FMT_B : FMT_R;
    endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational XLEN immediate from an instruction word and its format.
module imm_gen import decode_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);
    localparam int SH_W = $clog2(XLEN);
    logic signed [31:0] raw;
    logic shift;
    always_comb begin
        shift = instr[6:0] == OPC_ARI_I && instr[13:12] == 2'b01;
        case (fmt)
            FMT_I:   raw = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   raw = {instr[31:12], 12'b0};
            FMT_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: raw = '0;
        endcase
        // Shift amounts are zero-extended; everything else sign-extends from bit 31.
        imm = shift ? XLEN'(instr[20 +: SH_W]) : XLEN'(raw);
    end
endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: registered RV32I/RV64I pre-decode with a 2-entry skid buffer and flush.
// Define DECODE_ILLEGAL_EN to build the illegal-instruction checker; otherwise out_illegal is 0.
module decode_stage_pipe import decode_pkg::*; #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_rd_we,
    output logic            out_illegal
);
    localparam int ENT_W = PC_W + XLEN + FIELDS_W;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("decode_stage_pipe: XLEN must be 32 or 64");
    end

    imm_fmt_e fmt;
    dec_fields_t dec, out_f;
    logic [XLEN-1:0] imm;
    logic [6:0] opc, funct7;
    logic [4:0] rd;
    logic has_rd, shift, illegal;

    imm_gen #(.XLEN(XLEN)) u_imm (.instr(in_instr), .fmt(fmt), .imm(imm));

    always_comb begin
        opc = in_instr[6:0];
        fmt = fmt_of(opc);
        shift = opc == OPC_ARI_I && in_instr[13:12] == 2'b01;
        has_rd = fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J;
        rd = has_rd ? in_instr[11:7] : 5'd0;
        funct7 = fmt == FMT_R ? in_instr[31:25] :
                 shift ? {in_instr[31:26], XLEN == 64 ? 1'b0 : in_instr[25]} : 7'd0;
    end

    assign dec = '{
        opcode:  opc,
        rd:      rd,
        rs1:     (fmt == FMT_U || fmt == FMT_J) ? 5'd0 : in_instr[19:15],
        rs2:     (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B) ? in_instr[24:20] : 5'd0,
        funct3:  (fmt == FMT_U || fmt == FMT_J) ? 3'd0 : in_instr[14:12],
        funct7:  funct7,
        rd_we:   has_rd && rd != 5'd0 && !illegal,
        illegal: illegal
    };

`ifdef DECODE_ILLEGAL_EN
    logic known, bad_f3, bad_f7;
    logic [2:0] f3;
    always_comb begin
        f3 = in_instr[14:12];
        known = opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL || opc == OPC_JALR ||
                opc == OPC_BRANCH || opc == OPC_LOAD || opc == OPC_STORE ||
                opc == OPC_ARI_I || opc == OPC_ARI_R;
        bad_f3 = opc == OPC_BRANCH ? f3[2:1] == 2'b01 :
                 opc == OPC_LOAD   ? (f3 == 3'b111 || (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110))) :
                 opc == OPC_STORE  ? (f3[2] || (XLEN == 32 && f3 == 3'b011)) :
                 opc == OPC_JALR   ? f3 != 3'b000 : 1'b0;
        // funct7 0x20 is only legal for SUB/SRA and SRAI.
        bad_f7 = opc == OPC_ARI_R ? !(funct7 == 7'h00 || (funct7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) :
                 shift ? !(funct7 == 7'h00 || (funct7 == 7'h20 && f3 == 3'b101)) : 1'b0;
        illegal = !known || in_instr[1:0] != 2'b11 || bad_f3 || bad_f7;
    end
`else
    assign illegal = 1'b0;
`endif

    logic [ENT_W-1:0] main_q, skid_q;
    logic main_v, skid_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (skid_v) begin
            if (out_ready) begin
                main_q <= skid_q;
                skid_v <= 1'b0;
            end
        end else if (main_v && !out_ready) begin
            if (in_valid) begin
                skid_q <= {in_pc, imm, dec};
                skid_v <= 1'b1;
            end
        end else begin
            main_v <= in_valid;
            if (in_valid) main_q <= {in_pc, imm, dec};
        end
    end

    assign in_ready = !skid_v;
    assign out_valid = main_v;
    assign {out_pc, out_imm, out_f} = main_q;
    assign out_opcode = out_f.opcode;
    assign out_rd = out_f.rd;
    assign out_rs1 = out_f.rs1;
    assign out_rs2 = out_f.rs2;
    assign out_funct3 = out_f.funct3;
    assign out_funct7 = out_f.funct7;
    assign out_rd_we = out_f.rd_we;
    assign out_illegal = out_f.illegal;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed checks of decode_stage_pipe at XLEN 32 (a_*) and XLEN 64 (b_*).
module tb_decode_stage_pipe;
    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0;
    int n_run = 0, n_fail = 0;

`ifdef DECODE_ILLEGAL_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    logic a_in_ready, a_out_valid, a_rd_we, a_ill;
    logic [31:0] a_pc, a_imm;
    logic [6:0] a_opc, a_f7;
    logic [4:0] a_rd, a_rs1, a_rs2;
    logic [2:0] a_f3;
    logic b_in_ready, b_out_valid, b_rd_we, b_ill;
    logic [31:0] b_pc;
    logic [63:0] b_imm;
    logic [6:0] b_opc, b_f7;
    logic [4:0] b_rd, b_rs1, b_rs2;
    logic [2:0] b_f3;

    decode_stage_pipe #(.XLEN(32), .PC_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_pc), .out_opcode(a_opc), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
        .out_funct3(a_f3), .out_funct7(a_f7), .out_imm(a_imm), .out_rd_we(a_rd_we), .out_illegal(a_ill)
    );

    decode_stage_pipe #(.XLEN(64), .PC_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_pc), .out_opcode(b_opc), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
        .out_funct3(b_f3), .out_funct7(b_f7), .out_imm(b_imm), .out_rd_we(b_rd_we), .out_illegal(b_ill)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        check("rst_valid", a_out_valid, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_imm", b_imm, 0);
        check("rst_pc", a_pc, 0);
        rst_n = 1'b1;
        step();
        // back-to-back decode, one per cycle
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = 32'hFFF10093; in_pc = 32'h100; step();
        check("addi_valid", a_out_valid, 1);
        check("addi_pc", a_pc, 32'h100);
        check("addi_rd", a_rd, 1);
        check("addi_rs1", a_rs1, 2);
        check("addi_rs2", a_rs2, 0);
        check("addi_imm", a_imm, 32'hFFFFFFFF);
        check("addi_rd_we", a_rd_we, 1);
        check("addi_f7", a_f7, 0);
        check("addi_ill", a_ill, 0);
        in_instr = 32'h123452B7; in_pc = 32'h104; step();
        check("lui_imm64", b_imm, 64'h0000000012345000);
        check("lui_rd", b_rd, 5);
        check("lui_rs1", b_rs1, 0);
        check("lui_f3", b_f3, 0);
        in_instr = 32'hFE209EE3; in_pc = 32'h108; step();
        check("bne_imm64", b_imm, 64'hFFFFFFFFFFFFFFFC);
        check("bne_imm32", a_imm, 32'hFFFFFFFC);
        check("bne_rd", b_rd, 0);
        check("bne_rd_we", b_rd_we, 0);
        check("bne_rs2", a_rs2, 2);
        check("bne_f3", a_f3, 1);
        in_instr = 32'h42125193; in_pc = 32'h10C; step();
        check("srai_imm64", b_imm, 33);
        check("srai_f7_64", b_f7, 7'h20);
        check("srai_ill64", b_ill, 0);
        check("srai_imm32", a_imm, 1);
        check("srai_f7_32", a_f7, 7'h21);
        check("srai_ill32", a_ill, ILL);
        check("srai_we32", a_rd_we, !ILL);
        in_instr = 32'h409403B3; in_pc = 32'h110; step();
        check("sub_imm", a_imm, 0);
        check("sub_f7", a_f7, 7'h20);
        check("sub_rs2", a_rs2, 9);
        check("sub_rd", a_rd, 7);
        in_instr = 32'hFE532C23; in_pc = 32'h114; step();
        check("sw_imm", a_imm, 32'hFFFFFFF8);
        check("sw_rd", a_rd, 0);
        check("sw_rs2", a_rs2, 5);
        check("sw_rs1", a_rs1, 6);
        in_instr = 32'h008000EF; in_pc = 32'h118; step();
        check("jal_imm", b_imm, 8);
        check("jal_rd", a_rd, 1);
        check("jal_rs1", a_rs1, 0);
        check("jal_f3", a_f3, 0);
        in_valid = 1'b0; step();
        check("drain_valid", a_out_valid, 0);
        // stall: two accepts fill main+skid, third is held off
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF10093;
        in_pc = 32'h0; step();
        check("st0_pc", a_pc, 0);
        check("st0_in_ready", a_in_ready, 1);
        in_pc = 32'h4; step();
        check("st1_in_ready", a_in_ready, 0);
        in_pc = 32'h8; step();
        check("st2_in_ready", a_in_ready, 0);
        check("st2_pc", a_pc, 0);
        step();
        check("st3_valid", a_out_valid, 1);
        out_ready = 1'b1; step();
        check("rel0_pc", a_pc, 32'h4);
        check("rel0_in_ready", a_in_ready, 1);
        step();
        check("rel1_pc", a_pc, 32'h8);
        check("rel1_valid", a_out_valid, 1);
        in_valid = 1'b0; step();
        check("rel2_valid", a_out_valid, 0);
        // flush a full buffer with a concurrent input handshake
        out_ready = 1'b0; in_valid = 1'b1;
        in_pc = 32'h20; step();
        in_pc = 32'h24; step();
        check("fl_full", b_in_ready, 0);
        flush = 1'b1; in_pc = 32'h28; step();
        check("fl_valid", b_out_valid, 0);
        check("fl_in_ready", b_in_ready, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
        check("fl_none", a_out_valid, 0);
        // asynchronous reset with both entries full
        out_ready = 1'b0; in_valid = 1'b1;
        in_pc = 32'h30; step();
        in_pc = 32'h34; step();
        in_valid = 1'b0;
        check("ar_full", a_out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", a_out_valid, 0);
        check("ar_in_ready", a_in_ready, 1);
        check("ar_pc", a_pc, 0);
        check("ar_imm", b_imm, 0);
        check("ar_rd", a_rd, 0);
        #2 rst_n = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'h40; in_instr = 32'hFFF10093;
        step();
        check("post_pc", a_pc, 32'h40);
        check("post_imm", a_imm, 32'hFFFFFFFF);
        check("post_rd", a_rd, 1);
        in_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
